// File: rtl/subdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : subdiv_pkg
// Description : Shared types and constants for the subdivision pass chain.
//               Holds the stage encoding, the object-RAM owner encoding and
//               the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package subdiv_pkg;

    localparam int ADDR_WIDTH = 9;

    // Stage index; doubles as the bit position in stg_start / stg_busy.
    typedef enum logic [1:0] {
        STG_SPLIT = 2'd0,
        STG_NBR   = 2'd1,
        STG_AVG   = 2'd2
    } stage_e;

    // Object-RAM owner encoding seen by the shared RAM mux.
    localparam logic [1:0] c_RAM_SEL_NONE  = 2'd0;
    localparam logic [1:0] c_RAM_SEL_SPLIT = 2'd1;
    localparam logic [1:0] c_RAM_SEL_NBR   = 2'd2;
    localparam logic [1:0] c_RAM_SEL_AVG   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4,
        ST_FINISH    = 3'd5
    } seq_state_e;

    function automatic logic [1:0] ram_sel_of(input stage_e stg);
        case (stg)
            STG_SPLIT: return c_RAM_SEL_SPLIT;
            STG_NBR:   return c_RAM_SEL_NBR;
            STG_AVG:   return c_RAM_SEL_AVG;
            default:   return c_RAM_SEL_NONE;
        endcase
    endfunction

    function automatic stage_e next_stage(input stage_e stg);
        case (stg)
            STG_SPLIT: return STG_NBR;
            STG_NBR:   return STG_AVG;
            default:   return STG_SPLIT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_handshake.sv
`default_nettype none
// ============================================================================
// Module      : stage_handshake
// Description : Start/busy handshake helper for the currently selected stage.
//               Holds start until the stage acknowledges with busy, times out
//               the acknowledge, and flags the end of the stage's busy period.
// Ports       : clk, rst            - clock, async active-high reset
//               launch              - sequencer is in its launch cycle
//               wait_ack            - sequencer is waiting for busy to rise
//               wait_done           - sequencer is waiting for busy to fall
//               stage_busy          - busy of the selected stage
//               start               - start request for the selected stage
//               ack                 - selected stage acknowledged
//               timeout             - acknowledge window expired
//               busy_fell           - selected stage finished
// Revision    : 1.0 - initial release
// ============================================================================
module stage_handshake #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic launch,
    input  logic wait_ack,
    input  logic wait_done,
    input  logic stage_busy,
    output logic start,
    output logic ack,
    output logic timeout,
    output logic busy_fell
);

    localparam int c_TW = $clog2(ACK_TIMEOUT + 1);

    // Counts cycles with start asserted; the launch cycle counts as the first.
    logic [c_TW-1:0] r_ack_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_cnt <= '0;
        end else if (launch) begin
            r_ack_cnt <= c_TW'(1);
        end else if (wait_ack && (r_ack_cnt != c_TW'(ACK_TIMEOUT))) begin
            r_ack_cnt <= r_ack_cnt + c_TW'(1);
        end
    end

    // Stages sample start on the falling edge, so start is held from launch
    // until the acknowledge rather than pulsed.
    assign start     = launch | wait_ack;
    assign ack       = wait_ack & stage_busy;
    // Expires on the cycle where start has been high ACK_TIMEOUT cycles.
    assign timeout   = wait_ack & ~stage_busy & (r_ack_cnt >= c_TW'(ACK_TIMEOUT - 1));
    // Busy was seen high before entering the done wait, so a low level here
    // is the falling edge.
    assign busy_fell = wait_done & ~stage_busy;

endmodule
`default_nettype wire

// File: rtl/subdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : subdiv_sequencer
// Description : Runs N iterations of split -> neighbor build -> averager,
//               handshaking each stage, tracking mesh vertex/face counts and
//               driving the object-RAM owner select.
// Ports       : clk, rst            - clock, async active-high reset
//               go, abort           - run request / stop after current stage
//               iterations          - iteration count (clamped to MAX_ITER)
//               vertex/face_count_in- initial mesh counts, latched on go
//               stg_start/stg_busy  - per-stage handshake [0]=split [1]=nbr [2]=avg
//               split_*_count       - counts reported by the split stage
//               vertex/face_count   - current mesh counts
//               ram_sel             - object-RAM owner
//               iter_idx            - iteration in progress
//               busy, done, error   - run status, end pulse, sticky timeout
// Revision    : 1.0 - initial release
// ============================================================================
module subdiv_sequencer
    import subdiv_pkg::*;
#(
    parameter int MAX_ITER    = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [3:0]           iterations,
    input  logic [CNT_WIDTH-1:0] vertex_count_in,
    input  logic [CNT_WIDTH-1:0] face_count_in,
    output logic [2:0]           stg_start,
    input  logic [2:0]           stg_busy,
    input  logic [CNT_WIDTH-1:0] split_vertex_count,
    input  logic [CNT_WIDTH-1:0] split_face_count,
    output logic [CNT_WIDTH-1:0] vertex_count,
    output logic [CNT_WIDTH-1:0] face_count,
    output logic [1:0]           ram_sel,
    output logic [3:0]           iter_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam logic [3:0] c_MAX_ITER = 4'(MAX_ITER);

    seq_state_e           r_state;
    seq_state_e           w_state_nxt;
    stage_e               r_stage;
    logic [3:0]           r_iter_cnt;
    logic [3:0]           r_iter_idx;
    logic [CNT_WIDTH-1:0] r_vertex_count;
    logic [CNT_WIDTH-1:0] r_face_count;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic                 r_abort_seen;

    logic [3:0] w_iter_clamped;
    logic       w_launch;
    logic       w_wait_ack;
    logic       w_wait_done;
    logic       w_owned;
    logic       w_stage_busy;
    logic       w_hs_start;
    logic       w_ack;
    logic       w_timeout;
    logic       w_busy_fell;

    assign w_iter_clamped = (iterations > c_MAX_ITER) ? c_MAX_ITER : iterations;
    assign w_launch       = (r_state == ST_LAUNCH);
    assign w_wait_ack     = (r_state == ST_WAIT_ACK);
    assign w_wait_done    = (r_state == ST_WAIT_DONE);
    assign w_owned        = w_launch | w_wait_ack | w_wait_done;
    assign w_stage_busy   = stg_busy[r_stage];

    stage_handshake #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_handshake (
        .clk        (clk),
        .rst        (rst),
        .launch     (w_launch),
        .wait_ack   (w_wait_ack),
        .wait_done  (w_wait_done),
        .stage_busy (w_stage_busy),
        .start      (w_hs_start),
        .ack        (w_ack),
        .timeout    (w_timeout),
        .busy_fell  (w_busy_fell)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    w_state_nxt = (w_iter_clamped == 4'd0) ? ST_FINISH : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (w_ack) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_WAIT_DONE: begin
                if (w_busy_fell) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_abort_seen || abort) begin
                    w_state_nxt = ST_FINISH;
                end else if (r_stage != STG_AVG) begin
                    w_state_nxt = ST_LAUNCH;
                end else if ((r_iter_idx + 4'd1) < r_iter_cnt) begin
                    w_state_nxt = ST_LAUNCH;
                end else begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Run bookkeeping: counts, iteration/stage indices, status flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage        <= STG_SPLIT;
            r_iter_cnt     <= '0;
            r_iter_idx     <= '0;
            r_vertex_count <= '0;
            r_face_count   <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_abort_seen   <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FINISH);
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_vertex_count <= vertex_count_in;
                        r_face_count   <= face_count_in;
                        r_iter_cnt     <= w_iter_clamped;
                        r_iter_idx     <= '0;
                        r_stage        <= STG_SPLIT;
                        r_error        <= 1'b0;
                        r_busy         <= 1'b1;
                        // An abort arriving with go still lets the first
                        // stage run, then ends the run.
                        r_abort_seen   <= abort;
                    end
                end
                ST_WAIT_ACK: begin
                    if (w_timeout) begin
                        r_error <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_busy_fell && (r_stage == STG_SPLIT)) begin
                        r_vertex_count <= split_vertex_count;
                        r_face_count   <= split_face_count;
                    end
                end
                ST_NEXT: begin
                    if (w_state_nxt == ST_LAUNCH) begin
                        if (r_stage == STG_AVG) begin
                            r_stage    <= STG_SPLIT;
                            r_iter_idx <= r_iter_idx + 4'd1;
                        end else begin
                            r_stage <= next_stage(r_stage);
                        end
                    end
                end
                ST_FINISH: begin
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
            if ((r_state != ST_IDLE) && abort) begin
                r_abort_seen <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign stg_start    = w_hs_start ? (3'b001 << r_stage) : 3'b000;
    assign ram_sel      = w_owned ? ram_sel_of(r_stage) : c_RAM_SEL_NONE;
    assign vertex_count = r_vertex_count;
    assign face_count   = r_face_count;
    assign iter_idx     = r_iter_idx;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;

endmodule
`default_nettype wire

// File: doc/subdiv_sequencer.md
Name: subdiv_sequencer

Overview:
- Top-level scheduler for one subdivision pass chain. It runs N iterations of three stages in order: face split, neighbor-table build, vertex averager.
- Each stage has a start/busy handshake. The sequencer pulses start, waits for the stage to report busy, then waits for busy to drop.
- It also tracks the mesh vertex/face counts across iterations and drives the object-RAM port select used by the shared RAM mux.

Parameters:
- MAX_ITER, 8, largest accepted iteration count; `iterations` is clamped to this.
- ACK_TIMEOUT, 16, cycles allowed between asserting a stage start and seeing its busy rise.
- CNT_WIDTH, 32, width of the vertex/face count registers.

Ports:
- clk  in  1  system clock; all sequencer state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  single-cycle request to begin a run; ignored while busy.
- abort  in  1  stop after the current stage; no further stage is started.
- iterations  in  4  number of subdivision iterations; 0 = no-op run.
- vertex_count_in  in  CNT_WIDTH  initial mesh vertex count, latched on go.
- face_count_in  in  CNT_WIDTH  initial mesh face count, latched on go.
- stg_start  out  3  per-stage start, one-hot: [0]=split, [1]=nbr, [2]=avg.
- stg_busy  in  3  per-stage busy, same bit mapping.
- split_vertex_count  in  CNT_WIDTH  vertex count reported by the split stage, valid when its busy falls.
- split_face_count  in  CNT_WIDTH  face count reported by the split stage, valid when its busy falls.
- vertex_count  out  CNT_WIDTH  current mesh vertex count, broadcast to all stages.
- face_count  out  CNT_WIDTH  current mesh face count, broadcast to all stages.
- ram_sel  out  2  object-RAM owner: 0=none, 1=split, 2=nbr, 3=avg.
- iter_idx  out  4  index of the iteration in progress.
- busy  out  1  high from go acceptance until run end.
- done  out  1  one-cycle pulse when a run ends.
- error  out  1  sticky ack-timeout flag; cleared by the next accepted go.

Behaviour:
- Reset (async assert): every output is 0 and the state is IDLE. The count and iteration registers are also cleared.
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, NEXT, FINISH.
- IDLE:
  - On go, latch the counts and set iter_cnt = min(iterations, MAX_ITER); clear error; busy <= 1.
  - If iter_cnt == 0, go to FINISH. Otherwise set stage = 0 and go to LAUNCH.
- LAUNCH:
  - Assert stg_start[stage] and set ram_sel = stage+1.
  - Go to WAIT_ACK and reset the timeout counter.
- WAIT_ACK:
  - Hold stg_start[stage] high; stages sample start on the opposite clock edge, so a single-cycle pulse is insufficient.
  - When stg_busy[stage] = 1: drop start and go to WAIT_DONE.
  - If ACK_TIMEOUT cycles elapse with busy still low: set error, drop start, set ram_sel = 0, go to FINISH.
  - Busy already high at LAUNCH counts as an ack.
- WAIT_DONE:
  - Wait for stg_busy[stage] = 0; ram_sel stays held throughout.
  - On the falling edge of busy: if stage == split, load vertex_count/face_count from the split_* inputs that same cycle. Then go to NEXT.
- NEXT:
  - If abort was seen at any point since LAUNCH, go to FINISH.
  - Else if stage < 2: stage++, go to LAUNCH.
  - Else if iter_idx+1 < iter_cnt: iter_idx++, stage = 0, go to LAUNCH.
  - Otherwise go to FINISH.
- FINISH: ram_sel = 0, busy <= 0, done pulse for one cycle, go to IDLE.
- Ownership rules:
  - Exactly one stg_start bit is high at any time.
  - ram_sel is 0 outside LAUNCH/WAIT_ACK/WAIT_DONE.
  - ram_sel never changes while the owning stage is busy.
- Simultaneous events:
  - go together with abort in IDLE: the run starts and ends after the first stage.
  - go while busy is ignored.
  - abort in IDLE is ignored.
- Reset mid-run: all outputs drop immediately. Stages are not notified; the integrator resets them from the same rst.
- Arithmetic: the counters do not wrap. iter_idx is 4 bits and is bounded by MAX_ITER ≤ 15.

Decomposition:
- Package subdiv_pkg holds:
  - the stage enum (STG_SPLIT=0, STG_NBR=1, STG_AVG=2);
  - the ram_sel encoding constants;
  - the sequencer state enum;
  - ADDR_WIDTH=9.
- One sub-module, stage_handshake: drives start-hold-until-ack, the ack timeout and busy-fall detection for a single stage. It is instantiated once and multiplexed by the stage index.

Test Plan:
- iterations=1, counts 8/6, stage models ack after 2 cycles and finish after 20, split reports 26/24 -> start order split→nbr→avg; vertex_count=26 before nbr start; one done; busy low after.
- iterations=3 -> 9 start pulses in cyclic order; iter_idx goes 0,1,2; done once at the end.
- iterations=0 -> busy high for exactly 1 cycle then done; no stg_start; ram_sel stays 0.
- nbr model never asserts busy -> error=1 after 16 cycles; avg never started; done pulses; next go clears error.
- abort pulsed during split busy -> split completes, nbr never started, done pulses; also go during busy is ignored.
- rst asserted during WAIT_DONE -> all outputs 0 within the same cycle (async); a fresh go afterwards runs normally.
